// File: rtl/mvu_agu_pkg.sv
// mvu_agu_pkg: shared MVU types and default widths for the operand address
// generator. Default widths match the MVU CSR field sizes.
package mvu_agu_pkg;

    localparam int MVU_BADDR   = 15;
    localparam int MVU_BJUMP   = 15;
    localparam int MVU_BLENGTH = 15;
    localparam int MVU_BCNTDWN = 29;
    localparam int MVU_NJUMPS  = 5;

    typedef logic signed [MVU_BJUMP-1:0] jump_t;
    typedef logic [MVU_BLENGTH-1:0]      len_t;

    typedef enum logic {AGU_IDLE, AGU_RUN} agu_state_t;

endpackage

// File: rtl/mvu_agu_sel.sv
// mvu_agu_sel: priority encoder for the nested-loop step.
//   cnt_nz_i [NJUMPS-2:0] : per-level "counter still nonzero" flags (level 1 at bit 0)
//   zsel_o   [NJUMPS-1:0] : one-hot jump index to apply (bit NJUMPS-1 = outermost wrap)
//   reload_o [NJUMPS-2:0] : counters to reload with their configured length
// The lowest nonzero level wins; every level below it is exhausted and reloads.
// With no level nonzero the outermost jump is taken and all levels reload.
module mvu_agu_sel #(
    parameter int NJUMPS = 5
) (
    input  logic [NJUMPS-2:0] cnt_nz_i,
    output logic [NJUMPS-1:0] zsel_o,
    output logic [NJUMPS-2:0] reload_o
);

    logic found;

    always_comb begin
        zsel_o   = '0;
        reload_o = '0;
        found    = 1'b0;
        for (int i = 0; i < NJUMPS-1; i++) begin
            if (!found) begin
                if (cnt_nz_i[i]) begin
                    zsel_o[i] = 1'b1;
                    found     = 1'b1;
                end else begin
                    reload_o[i] = 1'b1;
                end
            end
        end
        if (!found) zsel_o[NJUMPS-1] = 1'b1;
    end

endmodule

// File: rtl/mvu_agu.sv
// mvu_agu: nested-loop address generator for one MVU operand stream.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start_i           : command kick (only honoured in IDLE)
//   countdown_i       : number of addresses in the command
//   baseaddr_i        : first address
//   jump_i            : signed jumps 0..NJUMPS-1
//   length_i          : loop lengths 1..NJUMPS-1
//   addr_o/valid_o    : address stream, advanced when ready_i is high
//   zsel_o            : one-hot jump taken when leaving the current address
//   first_o/last_o    : first / last address of the command
//   busy_o/done_o     : running / one-cycle completion pulse
module mvu_agu
    import mvu_agu_pkg::*;
#(
    parameter int BADDR   = MVU_BADDR,
    parameter int BJUMP   = MVU_BJUMP,
    parameter int BLENGTH = MVU_BLENGTH,
    parameter int BCNTDWN = MVU_BCNTDWN,
    parameter int NJUMPS  = MVU_NJUMPS
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_i,
    input  logic [BCNTDWN-1:0]                 countdown_i,
    input  logic [BADDR-1:0]                   baseaddr_i,
    input  logic [NJUMPS-1:0][BJUMP-1:0]       jump_i,
    input  logic [NJUMPS-2:0][BLENGTH-1:0]     length_i,
    output logic [BADDR-1:0]                   addr_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [NJUMPS-1:0]                  zsel_o,
    output logic                               first_o,
    output logic                               last_o,
    output logic                               busy_o,
    output logic                               done_o
);

    agu_state_t                        state_q, state_d;
    logic [BADDR-1:0]                  addr_q, addr_d;
    logic [BCNTDWN-1:0]                rem_q, rem_d;
    logic [NJUMPS-2:0][BLENGTH-1:0]    cnt_q, cnt_d;
    logic [NJUMPS-2:0][BLENGTH-1:0]    len_q, len_d;
    logic [NJUMPS-1:0][BJUMP-1:0]      jump_q, jump_d;
    logic                              first_q, first_d;
    logic                              done_q, done_d;

    logic [NJUMPS-2:0]                 cnt_nz;
    logic [NJUMPS-2:0]                 reload;
    logic [NJUMPS-1:0]                 zsel;
    logic signed [BJUMP-1:0]           jsel;
    logic                              run;

    assign run = (state_q == AGU_RUN);

    always_comb begin
        for (int i = 0; i < NJUMPS-1; i++) cnt_nz[i] = |cnt_q[i];
    end

    mvu_agu_sel #(.NJUMPS(NJUMPS)) u_sel (
        .cnt_nz_i (cnt_nz),
        .zsel_o   (zsel),
        .reload_o (reload)
    );

    // zsel is one-hot, so an OR-mux picks the jump.
    always_comb begin
        jsel = '0;
        for (int i = 0; i < NJUMPS; i++) begin
            if (zsel[i]) jsel = jump_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        jump_d  = jump_q;
        first_d = first_q;
        done_d  = 1'b0;
        case (state_q)
            AGU_IDLE: begin
                if (start_i) begin
                    if (countdown_i != '0) begin
                        state_d = AGU_RUN;
                        addr_d  = baseaddr_i;
                        rem_d   = countdown_i;
                        cnt_d   = length_i;
                        len_d   = length_i;
                        jump_d  = jump_i;
                        first_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            AGU_RUN: begin
                if (ready_i) begin
                    first_d = 1'b0;
                    rem_d   = rem_q - BCNTDWN'(1);
                    if (rem_q == BCNTDWN'(1)) begin
                        state_d = AGU_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Signed jump, sum wraps modulo 2^BADDR.
                        addr_d = addr_q + BADDR'(jsel);
                        for (int i = 0; i < NJUMPS-1; i++) begin
                            if (reload[i])    cnt_d[i] = len_q[i];
                            else if (zsel[i]) cnt_d[i] = cnt_q[i] - BLENGTH'(1);
                        end
                    end
                end
            end
            default: state_d = AGU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= AGU_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            jump_q  <= '0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            jump_q  <= jump_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    assign addr_o  = addr_q;
    assign valid_o = run;
    assign busy_o  = run;
    assign zsel_o  = run ? zsel : '0;
    assign first_o = first_q;
    assign last_o  = run && (rem_q == BCNTDWN'(1));
    assign done_o  = done_q;

endmodule

// File: tb/tb_mvu_agu.sv
// tb_mvu_agu: directed + randomized bench for mvu_agu. The expected address
// stream is derived from a mixed-radix view of the address index: level k has
// radix length_k+1, and the jump leaving address n belongs to the lowest level
// whose digit of n is still below its length (outermost jump if none).
module tb_mvu_agu;

    localparam int BADDR   = 15;
    localparam int BJUMP   = 15;
    localparam int BLENGTH = 15;
    localparam int BCNTDWN = 29;
    localparam int NJUMPS  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                           start_i;
    logic [BCNTDWN-1:0]             countdown_i;
    logic [BADDR-1:0]               baseaddr_i;
    logic [NJUMPS-1:0][BJUMP-1:0]   jump_i;
    logic [NJUMPS-2:0][BLENGTH-1:0] length_i;
    logic [BADDR-1:0]               addr_o;
    logic                           valid_o;
    logic                           ready_i;
    logic [NJUMPS-1:0]              zsel_o;
    logic                           first_o, last_o, busy_o, done_o;

    mvu_agu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .countdown_i (countdown_i),
        .baseaddr_i  (baseaddr_i),
        .jump_i      (jump_i),
        .length_i    (length_i),
        .addr_o      (addr_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .zsel_o      (zsel_o),
        .first_o     (first_o),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    int checks = 0;
    int errors = 0;

    int cfg_base, cfg_cnt;
    int cfg_jmp [NJUMPS];
    int cfg_len [NJUMPS-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Index of the jump applied when leaving the n-th address.
    function automatic int jidx(input int n);
        int q = n;
        for (int k = 0; k < NJUMPS-1; k++) begin
            int r = cfg_len[k] + 1;
            if ((q % r) < cfg_len[k]) return k;
            q = q / r;
        end
        return NJUMPS-1;
    endfunction

    task automatic set_cfg(input int base, input int cnt);
        cfg_base = base;
        cfg_cnt  = cnt;
        for (int k = 0; k < NJUMPS; k++)   cfg_jmp[k] = 0;
        for (int k = 0; k < NJUMPS-1; k++) cfg_len[k] = 0;
    endtask

    task automatic basic_cfg();
        set_cfg(100, 7);
        cfg_len[0] = 2; cfg_jmp[0] = 1; cfg_jmp[4] = 10;
    endtask

    task automatic nest_cfg();
        set_cfg(0, 8);
        cfg_len[0] = 1; cfg_len[1] = 1;
        cfg_jmp[0] = 1; cfg_jmp[1] = 4; cfg_jmp[4] = 16;
    endtask

    // Called at a negedge; returns at the negedge after start was sampled.
    task automatic issue();
        baseaddr_i  = cfg_base[BADDR-1:0];
        countdown_i = BCNTDWN'(cfg_cnt);
        for (int k = 0; k < NJUMPS; k++)   jump_i[k]   = BJUMP'(cfg_jmp[k]);
        for (int k = 0; k < NJUMPS-1; k++) length_i[k] = BLENGTH'(cfg_len[k]);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Follows one command to completion (or aborts with reset at abort_at).
    // Returns at the negedge of the done_o cycle.
    task automatic stream(input int stall_at, input int stall_len, input bit rnd, input int abort_at);
        int n = 0;
        int stalls = 0;
        int cyc = 0;
        logic [BADDR-1:0] ea;
        ea = cfg_base[BADDR-1:0];
        while (n < cfg_cnt && cyc < cfg_cnt * 20 + 50) begin
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_valid", valid_o, 0);
                chk("rst_addr",  addr_o,  0);
                chk("rst_zsel",  zsel_o,  0);
                chk("rst_first", first_o, 0);
                chk("rst_last",  last_o,  0);
                chk("rst_busy",  busy_o,  0);
                chk("rst_done",  done_o,  0);
                ready_i = 1'b0;
                start_i = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            chk("valid", valid_o, 1);
            chk("busy",  busy_o,  1);
            chk("done_run", done_o, 0);
            chk("addr",  addr_o, ea);
            chk("zsel",  zsel_o, 64'(1) << jidx(n));
            chk("first", first_o, n == 0);
            chk("last",  last_o,  n == cfg_cnt - 1);
            if (n == stall_at && stalls < stall_len) begin
                ready_i = 1'b0;
                stalls++;
            end else begin
                ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (rnd) begin
                // Configuration noise and stray starts must be ignored in RUN.
                start_i     = 1'($urandom_range(0, 1));
                baseaddr_i  = BADDR'($urandom);
                countdown_i = BCNTDWN'($urandom);
                for (int k = 0; k < NJUMPS; k++)   jump_i[k]   = BJUMP'($urandom);
                for (int k = 0; k < NJUMPS-1; k++) length_i[k] = BLENGTH'($urandom);
            end
            @(negedge clk);
            cyc++;
            if (ready_i) begin
                ea = ea + BADDR'(cfg_jmp[jidx(n)]);
                n++;
            end
        end
        start_i = 1'b0;
        ready_i = 1'b1;
        chk("timeout", n, cfg_cnt);
        chk("done",      done_o,  1);
        chk("busy_end",  busy_o,  0);
        chk("valid_end", valid_o, 0);
        chk("zsel_idle", zsel_o,  0);
        chk("last_idle", last_o,  0);
    endtask

    task automatic done_low();
        @(negedge clk);
        chk("done_once", done_o, 0);
        chk("valid_idle", valid_o, 0);
    endtask

    initial begin
        start_i = 1'b0; ready_i = 1'b0;
        countdown_i = '0; baseaddr_i = '0; jump_i = '0; length_i = '0;
        repeat (2) @(negedge clk);
        chk("reset_valid", valid_o, 0);
        chk("reset_addr",  addr_o,  0);
        chk("reset_zsel",  zsel_o,  0);
        chk("reset_busy",  busy_o,  0);
        chk("reset_done",  done_o,  0);
        chk("reset_first", first_o, 0);
        chk("reset_last",  last_o,  0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic loop: 100,101,102,112,113,114,124
        basic_cfg(); issue(); stream(-1, 0, 1'b0, -1); done_low();

        // Two-level nesting: 0,1,5,6,22,23,27,28
        nest_cfg(); issue(); stream(-1, 0, 1'b0, -1); done_low();

        // Stall three cycles at address 101
        basic_cfg(); issue(); stream(1, 3, 1'b0, -1); done_low();

        // Negative jump with wrap: 2, 0x7FFF, 0x7FFC
        set_cfg(2, 3); cfg_jmp[4] = -3;
        issue(); stream(-1, 0, 1'b0, -1); done_low();

        // Zero countdown: no valid, a single done pulse
        set_cfg(55, 0); cfg_jmp[4] = 1;
        issue();
        chk("zero_done",  done_o,  1);
        chk("zero_valid", valid_o, 0);
        chk("zero_busy",  busy_o,  0);
        done_low();

        // Reset after three addresses, then a clean restart from base
        basic_cfg(); issue(); stream(-1, 0, 1'b0, 3);
        chk("post_rst_valid", valid_o, 0);
        issue(); stream(-1, 0, 1'b0, -1); done_low();

        // Back-to-back: start in the done cycle is accepted
        basic_cfg(); issue(); stream(-1, 0, 1'b0, -1);
        nest_cfg(); issue(); stream(-1, 0, 1'b0, -1); done_low();

        // Randomized commands with random back-pressure and stray starts
        for (int t = 0; t < 25; t++) begin
            set_cfg(int'($urandom_range(0, 32767)), int'($urandom_range(1, 40)));
            for (int k = 0; k < NJUMPS; k++)   cfg_jmp[k] = int'($urandom_range(0, 32767)) - 16384;
            for (int k = 0; k < NJUMPS-1; k++) cfg_len[k] = int'($urandom_range(0, 3));
            issue();
            stream(int'($urandom_range(0, 10)), int'($urandom_range(0, 4)), 1'b1, -1);
            done_low();
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
